f_to_d_queue: RTL and testbench

F_TO_D_QUEUE -- requirements
Module: f_to_d_queue

---
 rtl/f_to_d_queue_pkg.sv | 6 +
 rtl/f_to_d_queue_if.sv | 27 ++
 rtl/fd_queue_mem.sv | 17 +
 rtl/f_to_d_queue.sv | 55 +++++
 tb/tb_f_to_d_queue.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/f_to_d_queue_pkg.sv
// f_to_d_queue_pkg: shared constants for the fetch-to-decode queue
package f_to_d_queue_pkg;
  localparam int XLEN_DEFAULT = 32;
  localparam int VPC_BITS_DEFAULT = 32;
  localparam logic [31:0] NOP = 32'h2000_0000;
endpackage

// File: rtl/f_to_d_queue_if.sv
// f_to_d_queue_if: fetch-side push and decode-side head signals of the queue
interface f_to_d_queue_if
  import f_to_d_queue_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int VPC_BITS = VPC_BITS_DEFAULT
);
  logic F_valid;
  logic F_ready;
  logic [VPC_BITS-1:0] F_pc;
  logic [XLEN-1:0] F_inst;
  logic F_BP_taken;
  logic [VPC_BITS-1:0] F_BP_target_pc;
  logic D_valid;
  logic [VPC_BITS-1:0] D_pc;
  logic [XLEN-1:0] D_inst;
  logic D_BP_taken;
  logic [VPC_BITS-1:0] D_BP_target_pc;
  modport master(
    output F_valid, F_pc, F_inst, F_BP_taken, F_BP_target_pc,
    input F_ready, D_valid, D_pc, D_inst, D_BP_taken, D_BP_target_pc
  );
  modport slave(
    input F_valid, F_pc, F_inst, F_BP_taken, F_BP_target_pc,
    output F_ready, D_valid, D_pc, D_inst, D_BP_taken, D_BP_target_pc
  );
endinterface

// File: rtl/fd_queue_mem.sv
// fd_queue_mem: entry storage, one write port and one async read port
module fd_queue_mem #(
  parameter int W = 97,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/f_to_d_queue.sv
// f_to_d_queue: first-word fall-through queue between fetch and decode
module f_to_d_queue
  import f_to_d_queue_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int VPC_BITS = VPC_BITS_DEFAULT,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           rst,
  f_to_d_queue_if.slave  q,
  input  logic           stall_D,
  input  logic           MEM_stall,
  input  logic           EX_taken,
  output logic [CW-1:0]  count
);
  localparam int AW = $clog2(DEPTH);
  localparam int W = 2 * VPC_BITS + XLEN + 1;
  logic [AW-1:0] wp, rp;
  logic push, pop;
  logic [W-1:0] rdata;
  logic [VPC_BITS-1:0] h_pc, h_tgt;
  logic [XLEN-1:0] h_inst;
  logic h_taken;
  assign q.F_ready = count < CW'(DEPTH);
  assign q.D_valid = count != '0;
  assign push = q.F_valid & q.F_ready & ~EX_taken;
  assign pop = q.D_valid & ~stall_D & ~MEM_stall & ~EX_taken;
  always_ff @(posedge clk) begin
    if (rst || EX_taken) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + AW'(push);
      rp <= rp + AW'(pop);
      count <= count + CW'(push) - CW'(pop);
    end
  end
  fd_queue_mem #(.W(W), .DEPTH(DEPTH)) u_mem (
    .clk(clk),
    .we(push),
    .waddr(wp),
    .wdata({q.F_pc, q.F_inst, q.F_BP_taken, q.F_BP_target_pc}),
    .raddr(rp),
    .rdata(rdata)
  );
  assign {h_pc, h_inst, h_taken, h_tgt} = rdata;
  // storage is undefined while empty, so mask the head to fixed idle values
  assign q.D_pc = q.D_valid ? h_pc : '0;
  assign q.D_inst = q.D_valid ? h_inst : XLEN'(NOP);
  assign q.D_BP_taken = q.D_valid & h_taken;
  assign q.D_BP_target_pc = q.D_valid ? h_tgt : '0;
endmodule

// File: tb/tb_f_to_d_queue.sv
// tb_f_to_d_queue: directed checks of the fetch-to-decode queue
module tb_f_to_d_queue;
  logic clk = 0, rst = 0, stall_D = 0, MEM_stall = 0, EX_taken = 0;
  logic [2:0] count;
  int checks = 0, errors = 0;
  f_to_d_queue_if #(.XLEN(32), .VPC_BITS(32)) bus ();
  f_to_d_queue #(.XLEN(32), .VPC_BITS(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .q(bus.slave), .stall_D(stall_D),
    .MEM_stall(MEM_stall), .EX_taken(EX_taken), .count(count)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return 32'hA500_0000 | pc;
  endfunction
  function automatic logic [31:0] tgt_of(input logic [31:0] pc);
    return pc + 32'h40;
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [31:0] pc);
    bus.F_valid = v;
    bus.F_pc = pc;
    bus.F_inst = inst_of(pc);
    bus.F_BP_taken = pc[2];
    bus.F_BP_target_pc = tgt_of(pc);
  endtask
  task automatic test_reset();
    drive(1'b0, 32'h0);
    rst = 1;
    step();
    rst = 0;
    step();
    checks += 6;
    if (bus.D_valid !== 1'b0) begin errors++; $display("FAIL reset_dvalid got %b exp 0", bus.D_valid); end
    if (bus.D_inst !== 32'h2000_0000) begin errors++; $display("FAIL reset_dinst got %h exp 20000000", bus.D_inst); end
    if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    if (bus.F_ready !== 1'b1) begin errors++; $display("FAIL reset_fready got %b exp 1", bus.F_ready); end
    if (bus.D_pc !== 32'h0 || bus.D_BP_target_pc !== 32'h0) begin errors++; $display("FAIL reset_dpc got %h/%h exp 0/0", bus.D_pc, bus.D_BP_target_pc); end
    if (bus.D_BP_taken !== 1'b0) begin errors++; $display("FAIL reset_taken got %b exp 0", bus.D_BP_taken); end
  endtask
  task automatic test_fill();
    stall_D = 1;
    MEM_stall = 1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h100 + 32'(4 * i));
      step();
      checks++;
      if (count !== 3'(i + 1)) begin errors++; $display("FAIL fill_count[%0d] got %0d exp %0d", i, count, i + 1); end
      if (i == 0) begin
        checks++;
        if (bus.D_valid !== 1'b1 || bus.D_pc !== 32'h100) begin errors++; $display("FAIL fill_fwft got %b/%h exp 1/100", bus.D_valid, bus.D_pc); end
      end
    end
    checks += 2;
    if (bus.F_ready !== 1'b0) begin errors++; $display("FAIL full_fready got %b exp 0", bus.F_ready); end
    if (bus.D_pc !== 32'h100) begin errors++; $display("FAIL full_head got %h exp 100", bus.D_pc); end
    drive(1'b1, 32'h200);
    step();
    checks += 2;
    if (count !== 3'd4) begin errors++; $display("FAIL fifth_push_count got %0d exp 4", count); end
    if (bus.D_pc !== 32'h100) begin errors++; $display("FAIL fifth_push_head got %h exp 100", bus.D_pc); end
    drive(1'b0, 32'h0);
  endtask
  task automatic test_drain();
    logic [31:0] pc;
    stall_D = 0;
    MEM_stall = 0;
    for (int i = 0; i < 4; i++) begin
      pc = 32'h100 + 32'(4 * i);
      checks++;
      if (bus.D_valid !== 1'b1 || bus.D_pc !== pc || bus.D_inst !== inst_of(pc) ||
          bus.D_BP_taken !== pc[2] || bus.D_BP_target_pc !== tgt_of(pc)) begin
        errors++;
        $display("FAIL drain[%0d] got v=%b pc=%h inst=%h t=%b tgt=%h exp pc=%h", i, bus.D_valid, bus.D_pc, bus.D_inst, bus.D_BP_taken, bus.D_BP_target_pc, pc);
      end
      step();
    end
    checks += 2;
    if (bus.D_valid !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL drain_empty got v=%b cnt=%0d exp 0/0", bus.D_valid, count); end
    if (bus.D_inst !== 32'h2000_0000) begin errors++; $display("FAIL drain_nop got %h exp 20000000", bus.D_inst); end
  endtask
  task automatic test_back_to_back();
    logic [31:0] pc;
    drive(1'b1, 32'h300);
    step();
    for (int i = 0; i < 10; i++) begin
      pc = 32'h300 + 32'(4 * i);
      drive(1'b1, pc + 32'h4);
      checks++;
      if (count !== 3'd1 || bus.D_valid !== 1'b1 || bus.D_pc !== pc || bus.D_inst !== inst_of(pc)) begin
        errors++;
        $display("FAIL b2b[%0d] got cnt=%0d v=%b pc=%h exp cnt=1 pc=%h", i, count, bus.D_valid, bus.D_pc, pc);
      end
      step();
    end
    drive(1'b0, 32'h0);
    checks++;
    if (bus.D_pc !== 32'h328 || count !== 3'd1) begin errors++; $display("FAIL b2b_last got pc=%h cnt=%0d exp 328/1", bus.D_pc, count); end
    step();
    checks++;
    if (count !== 3'd0 || bus.D_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty got cnt=%0d v=%b exp 0/0", count, bus.D_valid); end
  endtask
  task automatic test_flush();
    stall_D = 1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h400 + 32'(4 * i));
      step();
    end
    checks++;
    if (count !== 3'd3) begin errors++; $display("FAIL flush_pre got %0d exp 3", count); end
    drive(1'b1, 32'h40C);
    EX_taken = 1;
    step();
    EX_taken = 0;
    drive(1'b0, 32'h0);
    checks++;
    if (count !== 3'd0 || bus.D_valid !== 1'b0) begin errors++; $display("FAIL flush got cnt=%0d v=%b exp 0/0", count, bus.D_valid); end
    stall_D = 0;
    step();
    checks++;
    if (count !== 3'd0 || bus.D_valid !== 1'b0) begin errors++; $display("FAIL flush_absent got cnt=%0d v=%b exp 0/0", count, bus.D_valid); end
    EX_taken = 1;
    step();
    EX_taken = 0;
    checks++;
    if (count !== 3'd0 || bus.F_ready !== 1'b1) begin errors++; $display("FAIL flush_empty got cnt=%0d rdy=%b exp 0/1", count, bus.F_ready); end
    stall_D = 1;
    drive(1'b1, 32'h500);
    step();
    drive(1'b0, 32'h0);
    checks++;
    if (count !== 3'd1 || bus.D_pc !== 32'h500) begin errors++; $display("FAIL post_flush got cnt=%0d pc=%h exp 1/500", count, bus.D_pc); end
    stall_D = 0;
    step();
  endtask
  task automatic test_stall_reset();
    MEM_stall = 1;
    drive(1'b1, 32'h600);
    step();
    drive(1'b1, 32'h604);
    step();
    checks++;
    if (count !== 3'd2 || bus.D_pc !== 32'h600) begin errors++; $display("FAIL stall_pre got cnt=%0d pc=%h exp 2/600", count, bus.D_pc); end
    drive(1'b1, 32'h608);
    step();
    checks++;
    if (count !== 3'd3 || bus.D_pc !== 32'h600) begin errors++; $display("FAIL stall_push got cnt=%0d pc=%h exp 3/600", count, bus.D_pc); end
    MEM_stall = 0;
    drive(1'b1, 32'h60C);
    rst = 1;
    step();
    rst = 0;
    drive(1'b0, 32'h0);
    checks += 2;
    if (count !== 3'd0 || bus.D_valid !== 1'b0 || bus.F_ready !== 1'b1) begin errors++; $display("FAIL rst_mid got cnt=%0d v=%b rdy=%b exp 0/0/1", count, bus.D_valid, bus.F_ready); end
    if (bus.D_inst !== 32'h2000_0000 || bus.D_pc !== 32'h0) begin errors++; $display("FAIL rst_mid_nop got inst=%h pc=%h exp 20000000/0", bus.D_inst, bus.D_pc); end
    step();
    checks++;
    if (count !== 3'd0 || bus.D_valid !== 1'b0) begin errors++; $display("FAIL rst_stays got cnt=%0d v=%b exp 0/0", count, bus.D_valid); end
  endtask
  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_flush();
    test_stall_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
